// File: rtl/ysyx_23060236_rd_arbiter.sv
// Round-robin read arbiter: NUM_M AXI-style read masters share one external AXI read port and the CLINT port.
// Optional CLINT address decode is enabled by defining YSYX_23060236_CLINT_EN; otherwise every request goes external.
module ysyx_23060236_rd_arbiter #(
    parameter int          NUM_M      = 2,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    // upstream masters
    input  logic [NUM_M-1:0]     m_arvalid,
    output logic [NUM_M-1:0]     m_arready,
    input  logic [32*NUM_M-1:0]  m_araddr,
    input  logic [8*NUM_M-1:0]   m_arlen,
    input  logic [3*NUM_M-1:0]   m_arsize,
    input  logic [2*NUM_M-1:0]   m_arburst,
    output logic [NUM_M-1:0]     m_rvalid,
    input  logic [NUM_M-1:0]     m_rready,
    output logic [31:0]          m_rdata,
    output logic [1:0]           m_rresp,
    output logic                 m_rlast,
    // external AXI read master
    output logic                 ext_arvalid,
    input  logic                 ext_arready,
    output logic [31:0]          ext_araddr,
    output logic [3:0]           ext_arid,
    output logic [7:0]           ext_arlen,
    output logic [2:0]           ext_arsize,
    output logic [1:0]           ext_arburst,
    input  logic                 ext_rvalid,
    output logic                 ext_rready,
    input  logic [31:0]          ext_rdata,
    input  logic [1:0]           ext_rresp,
    input  logic                 ext_rlast,
    // CLINT single-beat read port
    output logic                 clint_arvalid,
    input  logic                 clint_arready,
    output logic [31:0]          clint_araddr,
    input  logic                 clint_rvalid,
    output logic                 clint_rready,
    input  logic [31:0]          clint_rdata,
    input  logic [1:0]           clint_rresp
);

    localparam int              GW      = $clog2(NUM_M);
    localparam int              GW1     = GW + 1;
    localparam logic [GW:0]     NUM_M_W = GW1'(NUM_M);
    localparam logic [GW-1:0]   LAST_M  = GW'(NUM_M - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [GW-1:0] grant_r;
    logic [GW-1:0] last_grant_r;
    logic          target_clint_r;
    logic [31:0]   araddr_r;
    logic [7:0]    arlen_r;
    logic [2:0]    arsize_r;
    logic [1:0]    arburst_r;

    logic [31:0]   araddr_a  [NUM_M];
    logic [7:0]    arlen_a   [NUM_M];
    logic [2:0]    arsize_a  [NUM_M];
    logic [1:0]    arburst_a [NUM_M];

    logic          pick_found_s;
    logic [GW-1:0] pick_idx_s;
    logic [GW:0]   cand_s;
    logic          hit_s;
    logic          clint_hit_s;
    logic          pick_clint_s;

    logic          addr_phase_s;
    logic          data_phase_s;
    logic          tgt_arready_s;
    logic          tgt_rvalid_s;
    logic          ar_fire_s;
    logic          r_last_fire_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign araddr_a[gi]  = m_araddr[gi*32 +: 32];
            assign arlen_a[gi]   = m_arlen[gi*8 +: 8];
            assign arsize_a[gi]  = m_arsize[gi*3 +: 3];
            assign arburst_a[gi] = m_arburst[gi*2 +: 2];
        end
    endgenerate

    // Round-robin pick: first requester scanning upward from last_grant+1, wrapping at NUM_M.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int off = 1; off <= NUM_M; off++) begin
            cand_s       = {1'b0, last_grant_r} + off[GW:0];
            cand_s       = (cand_s >= NUM_M_W) ? (cand_s - NUM_M_W) : cand_s;
            hit_s        = m_arvalid[cand_s[GW-1:0]] & ~pick_found_s;
            pick_idx_s   = hit_s ? cand_s[GW-1:0] : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    assign clint_hit_s = ((araddr_a[pick_idx_s] & CLINT_MASK) == CLINT_BASE);

`ifdef YSYX_23060236_CLINT_EN
    assign pick_clint_s = clint_hit_s;
`else
    logic unused_clint_s;
    assign unused_clint_s = clint_hit_s;
    assign pick_clint_s   = 1'b0;
`endif

    // Phases are forced idle while reset is high so nothing leaks out before the state clears.
    assign addr_phase_s  = (state_r == S_ADDR) & ~reset;
    assign data_phase_s  = (state_r == S_DATA) & ~reset;
    assign tgt_arready_s = target_clint_r ? clint_arready : ext_arready;
    assign tgt_rvalid_s  = target_clint_r ? clint_rvalid : ext_rvalid;
    assign ar_fire_s     = addr_phase_s & tgt_arready_s;
    assign r_last_fire_s = data_phase_s & tgt_rvalid_s & m_rready[grant_r]
                         & (target_clint_r | ext_rlast);

    // Next-state logic for the IDLE -> ADDR -> DATA cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  state_nx_s = pick_found_s ? S_ADDR : S_IDLE;
            S_ADDR:  state_nx_s = ar_fire_s ? S_DATA : S_ADDR;
            S_DATA:  state_nx_s = r_last_fire_s ? S_IDLE : S_DATA;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, grant bookkeeping and latched AR fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= S_IDLE;
            grant_r        <= '0;
            last_grant_r   <= LAST_M;
            target_clint_r <= 1'b0;
            araddr_r       <= 32'h0000_0000;
            arlen_r        <= 8'h00;
            arsize_r       <= 3'b000;
            arburst_r      <= 2'b00;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == S_IDLE) && pick_found_s) begin
                grant_r        <= pick_idx_s;
                target_clint_r <= pick_clint_s;
                araddr_r       <= araddr_a[pick_idx_s];
                arlen_r        <= arlen_a[pick_idx_s];
                arsize_r       <= arsize_a[pick_idx_s];
                arburst_r      <= arburst_a[pick_idx_s];
            end
            if (r_last_fire_s) begin
                last_grant_r <= grant_r;
            end
        end
    end

    assign ext_arvalid = addr_phase_s & ~target_clint_r;
    assign ext_araddr  = araddr_r;
    assign ext_arid    = 4'(grant_r);
    assign ext_arlen   = arlen_r;
    assign ext_arsize  = arsize_r;
    assign ext_arburst = arburst_r;
    assign ext_rready  = data_phase_s & ~target_clint_r & m_rready[grant_r];

`ifdef YSYX_23060236_CLINT_EN
    assign clint_arvalid = addr_phase_s & target_clint_r;
    assign clint_araddr  = araddr_r;
    assign clint_rready  = data_phase_s & target_clint_r & m_rready[grant_r];
`else
    assign clint_arvalid = 1'b0;
    assign clint_araddr  = 32'h0000_0000;
    assign clint_rready  = 1'b0;
`endif

    // Only the granted master sees ready/valid; CLINT beats always look like the last beat.
    always_comb begin
        m_arready          = '0;
        m_rvalid           = '0;
        m_arready[grant_r] = addr_phase_s & tgt_arready_s;
        m_rvalid[grant_r]  = data_phase_s & tgt_rvalid_s;
        m_rdata            = target_clint_r ? clint_rdata : ext_rdata;
        m_rresp            = target_clint_r ? clint_rresp : ext_rresp;
        m_rlast            = target_clint_r ? 1'b1 : ext_rlast;
    end

endmodule

// File: doc/ysyx_23060236_rd_arbiter.md
YSYX_23060236_RD_ARBITER -- requirements
Module: ysyx_23060236_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2: number of upstream read masters; legal range 2..8.
REQ-002 SHALL have parameter CLINT_BASE, default 32'h0200_0000: CLINT region base.
REQ-003 SHALL have parameter CLINT_MASK, default 32'hFFFF_0000: CLINT region match mask.
REQ-004 SHALL have port clock, input, 1: clock; reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have m_arvalid in NUM_M, m_arready out NUM_M, m_araddr in 32*NUM_M, m_arlen in 8*NUM_M, m_arsize in 3*NUM_M, m_arburst in 2*NUM_M: per-master AR channels, master i in slice i.
REQ-006 SHALL have m_rvalid out NUM_M, m_rready in NUM_M, and broadcast m_rdata out 32, m_rresp out 2, m_rlast out 1: per-master R channels.
REQ-007 SHALL have ext_arvalid out 1, ext_arready in 1, ext_araddr out 32, ext_arid out 4, ext_arlen out 8, ext_arsize out 3, ext_arburst out 2, and ext_rvalid in 1, ext_rready out 1, ext_rdata in 32, ext_rresp in 2, ext_rlast in 1: external AXI read master.
REQ-008 SHALL have clint_arvalid out 1, clint_arready in 1, clint_araddr out 32, clint_rvalid in 1, clint_rready out 1, clint_rdata in 32, clint_rresp in 2: CLINT single-beat read port.

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with state, grant index, target select and latched AR fields all registered.
REQ-010 IDLE: if any m_arvalid is set, SHALL pick the winner round-robin starting at (last_grant+1) mod NUM_M, latch its AR fields, set target = CLINT when (araddr & CLINT_MASK) == CLINT_BASE else EXT, and enter ADDR next cycle.
REQ-011 ADDR: SHALL drive target arvalid=1 with the latched fields, ext_arid = grant index, and m_arready[grant] = target arready combinationally; on the arvalid&arready cycle SHALL enter DATA.
REQ-012 DATA: SHALL route target rvalid to m_rvalid[grant] and m_rready[grant] to target rready; every other m_rvalid and m_arready SHALL be 0.
REQ-013 DATA exit: on an rvalid&rready beat with rlast SHALL enter IDLE and set last_grant = grant; CLINT beats SHALL be treated as rlast=1.
REQ-014 Burst: an ext arlen=N transfer SHALL hold the grant for N+1 beats; the first handshake with ext_rlast=1 ends it.
REQ-015 Latency: master arvalid in IDLE -> downstream arvalid exactly 1 cycle later; R data SHALL pass combinationally, 0 cycles.
REQ-016 Requests arriving during ADDR/DATA SHALL wait; masters SHALL hold arvalid stable until m_arready.
REQ-017 Simultaneous requests: with last_grant=k, master (k+1) mod NUM_M wins if requesting, then (k+2), and so on; no master starves.
REQ-018 A master deasserting arvalid in IDLE before selection SHALL simply not be selected; m_arready SHALL be 0 in IDLE and DATA.
REQ-019 rresp from the target SHALL be forwarded unchanged; an error response SHALL still terminate per REQ-013.

Reset
REQ-020 On reset SHALL go to IDLE with last_grant = NUM_M-1, so master 0 has first priority.
REQ-021 During/after reset SHALL drive all arvalid, rvalid, arready and rready outputs to 0; the latched address SHALL be 0.
REQ-022 Reset mid-burst SHALL abandon the transaction with no further beats forwarded.

Configuration
REQ-023 Macro YSYX_23060236_CLINT_EN defined: decode per REQ-010.
REQ-024 Macro YSYX_23060236_CLINT_EN undefined: all requests SHALL target EXT, clint_arvalid and clint_rready SHALL be tied to 0, and clint_araddr SHALL be tied to 0.

Verification
REQ-025 Single read: m0 araddr=0x3000_0000, arlen=0 -> ext_arvalid 1 cycle later with ext_arid=0; ext_rdata=0xDEADBEEF, rlast=1 -> m_rvalid[0]=1 and m_rdata=0xDEADBEEF; FSM returns to IDLE.
REQ-026 Contention: m0 and m1 both request at reset -> m0 served first, then m1; repeated back-to-back requests from both -> grants alternate 0,1,0,1.
REQ-027 Burst: m1 arlen=3 -> 4 beats forwarded only to m1; m0 request held off until the 4th beat with ext_rlast=1, then granted.
REQ-028 CLINT: araddr=0x0200_BFF8 -> clint_arvalid=1 and ext_arvalid=0; clint_rdata=0x1234 -> m_rvalid with m_rlast=1; with macro undefined the same address goes to ext.
REQ-029 Backpressure/reset: ext_arready held low 5 cycles -> ext_arvalid and ext_araddr stable; reset asserted mid-burst -> all valid/ready outputs 0 next cycle and master 0 has first priority after reset.
